// File: rtl/fir.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fir : direct-form FIR, full-precision MAC, arithmetic shift, 32-bit saturate
// Revision: 1.0
// ----------------------------------------------------------------------------
module fir #(
  parameter int                     TAPS   = 8,
  parameter int                     CW     = 16,
  parameter logic [TAPS*CW-1:0]     COEFFS = {16'sd1, 16'sd2, 16'sd3, 16'sd4,
                                              16'sd4, 16'sd3, 16'sd2, 16'sd1},
  parameter int                     SHIFT  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] x,
  output logic [31:0] y
);

  localparam int PW    = 32 + CW;
  localparam int ACC_W = PW + $clog2(TAPS);

  logic [31:0]             d_q   [1:TAPS-1];
  logic [31:0]             d_d   [1:TAPS-1];
  logic [31:0]             y_q;
  logic [31:0]             y_d;

  logic [31:0]             tap   [0:TAPS-1];
  logic [CW-1:0]           coef  [0:TAPS-1];
  logic signed [PW-1:0]    prod  [0:TAPS-1];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;

  // Tap 0 is the live input; higher taps come from the delay line.
  assign tap[0] = x;

  for (genvar i = 1; i < TAPS; i++) begin : g_tap
    assign tap[i] = d_q[i];
  end

  for (genvar i = 0; i < TAPS; i++) begin : g_mul
    assign coef[i] = COEFFS[i*CW +: CW];
    assign prod[i] = $signed(tap[i]) * $signed(coef[i]);
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < TAPS; i++) begin
      acc = acc + $signed({{(ACC_W-PW){prod[i][PW-1]}}, prod[i]});
    end
  end

  assign shifted = acc >>> SHIFT;

  // Bits above 31 must all equal the sign bit for the result to fit in 32 bits.
  always_comb begin
    y_d = shifted[31:0];
    if (!shifted[ACC_W-1] && (|shifted[ACC_W-2:31])) begin
      y_d = 32'h7FFF_FFFF;
    end else if (shifted[ACC_W-1] && !(&shifted[ACC_W-2:31])) begin
      y_d = 32'h8000_0000;
    end
  end

  always_comb begin
    d_d[1] = x;
    for (int i = 2; i < TAPS; i++) begin
      d_d[i] = d_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q <= '0;
      for (int i = 1; i < TAPS; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      y_q <= y_d;
      for (int i = 1; i < TAPS; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign y = y_q;

endmodule
`default_nettype wire

// File: tb/tb_fir.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fir : randomized and directed checks of fir against a sample-history model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_fir;

  localparam int TAPS  = 8;
  localparam int SHIFT = 0;

  logic        clk;
  logic        rst_n;
  logic [31:0] x;
  logic [31:0] y;

  int n_cmp = 0;
  int n_err = 0;

  longint      hist [TAPS];
  int          cref [TAPS] = '{1, 2, 3, 4, 4, 3, 2, 1};
  logic [31:0] y_exp;

  fir dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // History-based reference: keep the last TAPS samples, form the dot product.
  function automatic logic [31:0] model_push(input logic [31:0] xv);
    longint s;
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = longint'($signed(xv));
    s = 0;
    for (int i = 0; i < TAPS; i++) s += hist[i] * longint'(cref[i]);
    s = s >>> SHIFT;
    if (s > 64'sd2147483647)       return 32'h7FFF_FFFF;
    else if (s < -64'sd2147483648) return 32'h8000_0000;
    else                           return s[31:0];
  endfunction

  task automatic step(input logic [31:0] xv, input logic rv, input string tag);
    x     = xv;
    rst_n = rv;
    @(posedge clk);
    if (!rv) begin
      foreach (hist[i]) hist[i] = 0;
      y_exp = '0;
    end else begin
      y_exp = model_push(xv);
    end
    #1;
    n_cmp++;
    assert (y === y_exp) else begin
      n_err++;
      $error("FAIL %s: y=%0d (0x%08h) expected %0d (0x%08h)", tag,
             $signed(y), y, $signed(y_exp), y_exp);
    end
  endtask

  task automatic expect_const(input logic [31:0] ev, input string tag);
    n_cmp++;
    assert (y === ev) else begin
      n_err++;
      $error("FAIL %s: y=%0d expected %0d", tag, $signed(y), $signed(ev));
    end
  endtask

  int imp_pos [9] = '{1, 2, 3, 4, 4, 3, 2, 1, 0};
  int imp_neg [9] = '{-7, -14, -21, -28, -28, -21, -14, -7, 0};
  int stp     [9] = '{1000, 3000, 6000, 10000, 14000, 17000, 19000, 20000, 20000};

  initial begin
    x     = '0;
    rst_n = 1'b0;
    foreach (hist[i]) hist[i] = 0;

    // Reset held with a nonzero input, then zeros: nothing of 12345 may leak.
    for (int k = 0; k < 3; k++)  step(32'd12345, 1'b0, "reset_hold");
    for (int k = 0; k < 10; k++) step(32'd0, 1'b1, "post_reset_zero");

    // Impulse response.
    for (int k = 0; k < 9; k++) begin
      step((k == 0) ? 32'd1 : 32'd0, 1'b1, "impulse");
      expect_const(imp_pos[k], "impulse_const");
    end

    // Step response.
    step(32'd0, 1'b0, "reset");
    for (int k = 0; k < 9; k++) begin
      step(32'd1000, 1'b1, "step");
      expect_const(stp[k], "step_const");
    end

    // Negative impulse.
    step(32'd0, 1'b0, "reset");
    for (int k = 0; k < 9; k++) begin
      step((k == 0) ? 32'hFFFF_FFF9 : 32'd0, 1'b1, "neg_impulse");
      expect_const(imp_neg[k], "neg_impulse_const");
    end

    // Positive and negative saturation.
    step(32'd0, 1'b0, "reset");
    for (int k = 0; k < 10; k++) begin
      step(32'h7FFF_FFFF, 1'b1, "sat_pos");
      expect_const(32'h7FFF_FFFF, "sat_pos_const");
    end
    step(32'd0, 1'b0, "reset");
    for (int k = 0; k < 10; k++) begin
      step(32'h8000_0000, 1'b1, "sat_neg");
      expect_const(32'h8000_0000, "sat_neg_const");
    end

    // Random stream with a one-edge reset at sample 50.
    for (int k = 0; k < 100; k++) begin
      if (k == 50) begin
        step($urandom, 1'b0, "rand_midreset");
        expect_const(32'd0, "rand_midreset_zero");
      end else begin
        step($urandom, 1'b1, "rand_stream");
      end
    end

    // Small-magnitude random samples exercise the unsaturated path.
    for (int k = 0; k < 40; k++) begin
      step(32'($signed($urandom_range(0, 200000)) - 100000), 1'b1, "rand_small");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
